// File: rtl/ecc_secded_dec_pipe_pkg.sv
// ecc_secded_dec_pipe_pkg
//   Shared definitions for the SECDED (extended Hamming) decoder family.
//   CHK_W_F(data_w) : number of check bits (Hamming bits + overall parity)
//   DPOS_F(idx)     : codeword position of data bit idx (powers of two skipped)
//   syn_class_e     : classification of a decoded {parity, syndrome} pair
package ecc_secded_dec_pipe_pkg;

  typedef enum logic [1:0] {
    SYN_CLEAN = 2'd0,  // no error
    SYN_PAR   = 2'd1,  // single error on a parity bit (incl. overall parity)
    SYN_DATA  = 2'd2,  // single error on a data bit, correctable
    SYN_DBIT  = 2'd3   // uncorrectable
  } syn_class_e;

  // Smallest r with 2^r >= data_w + r + 1, plus one overall parity bit.
  function automatic int CHK_W_F(input int data_w);
    int res;
    res = 0;
    for (int k = 1; k < 16; k++) begin
      if ((res == 0) && ((1 << k) >= (data_w + k + 1))) begin
        res = k + 1;
      end
    end
    return res;
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic int DPOS_F(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < 1024; p++) begin
      if ((pos == 0) && ((p & (p - 1)) != 0)) begin
        if (cnt == idx) begin
          pos = p;
        end
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_secded_dec_pipe_if.sv
// ecc_secded_dec_pipe_if
//   Read-path bus around the decoder.
//   in_*  : raw word from the RAM read port (valid, address tag, data, check bits)
//   out_* : decoded word towards the consumer (valid, tag, data, error flags)
//   master : RAM side / consumer (drives in_*, observes out_*)
//   slave  : the decoder
interface ecc_secded_dec_pipe_if #(
  parameter int DATA_W = 64,
  parameter int CHK_W  = 8,
  parameter int ADDR_W = 16
);
  logic              in_vld;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] ecc_data_in;
  logic [CHK_W-1:0]  ecc_chkbits_in;
  logic              out_vld;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] ecc_data_out;
  logic              ecc_sbit_err;
  logic              ecc_dbit_err;

  modport master (
    output in_vld, in_addr, ecc_data_in, ecc_chkbits_in,
    input  out_vld, out_addr, ecc_data_out, ecc_sbit_err, ecc_dbit_err
  );

  modport slave (
    input  in_vld, in_addr, ecc_data_in, ecc_chkbits_in,
    output out_vld, out_addr, ecc_data_out, ecc_sbit_err, ecc_dbit_err
  );
endinterface

// File: rtl/ecc_secded_dec_pipe_syn.sv
// ecc_secded_syn
//   Combinational check-bit generator, usable by both encoder and decoder.
//   i_data : DATA_W data bits
//   o_chk  : CHK_W check bits; [CHK_W-2:0] Hamming bits, [CHK_W-1] overall parity
module ecc_secded_syn
  import ecc_secded_dec_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CHK_W  = 8
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CHK_W-1:0]  o_chk
);

  logic [CHK_W-2:0] w_low;

  // Each Hamming bit covers the data bits whose position has that bit set;
  // the masks are elaboration-time constants.
  for (genvar i = 0; i < CHK_W - 1; i++) begin : g_chk
    logic [DATA_W-1:0] w_mask;
    for (genvar j = 0; j < DATA_W; j++) begin : g_mask
      localparam int POS = DPOS_F(j);
      assign w_mask[j] = POS[i];
    end
    assign w_low[i] = ^(i_data & w_mask);
  end

  assign o_chk = {(^i_data) ^ (^w_low), w_low};

endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// ecc_secded_dec_pipe
//   Three-stage SECDED decoder for a RAM read path with error counters,
//   first-error log and interrupt. Fixed latency of 3 enabled cycles.
//   ecc_clk / ecc_reset (sync, active-high) / ecc_clken (freezes everything)
//   ecc_correct_n : 1 = detect only
//   bus           : in_* raw word, out_* decoded word and error flags
//   cnt_clr, sbit_cnt, dbit_cnt : saturating error counters and their clear
//   err_log_*     : first-error log (ack releases it), err_irq = err_log_vld
module ecc_secded_dec_pipe
  import ecc_secded_dec_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CHK_W  = 8,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  ecc_clk,
  input  logic                  ecc_reset,
  input  logic                  ecc_clken,
  input  logic                  ecc_correct_n,
  ecc_secded_dec_pipe_if.slave  bus,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      sbit_cnt,
  output logic [CNT_W-1:0]      dbit_cnt,
  input  logic                  err_log_ack,
  output logic                  err_log_vld,
  output logic [ADDR_W-1:0]     err_log_addr,
  output logic [CHK_W-1:0]      err_log_syn,
  output logic                  err_log_dbit,
  output logic                  err_log_ovf,
  output logic                  err_irq
);

  localparam int               SYN_W    = CHK_W - 1;
  localparam logic [SYN_W-1:0] LAST_POS = SYN_W'(DATA_W + CHK_W - 1);
  localparam logic [SYN_W-1:0] SYN_ONE  = SYN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (CHK_W != CHK_W_F(DATA_W)) begin : g_bad_chk_w
    $error("ecc_secded_dec_pipe: CHK_W does not match CHK_W_F(DATA_W)");
  end

  // Clear wins over the old value; a same-cycle increment then yields 1.
  function automatic logic [CNT_W-1:0] sat_cnt_f(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic clr);
    logic [CNT_W-1:0] nxt;
    if (clr) begin
      nxt = inc ? CNT_ONE : {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      nxt = cnt + CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // Stage 1
  logic              r_s1_vld, r_s1_cor_n;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;
  logic [CHK_W-1:0]  r_s1_chk;
  // Stage 2
  logic              r_s2_vld, r_s2_cor_n, r_s2_par;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [DATA_W-1:0] r_s2_data;
  logic [SYN_W-1:0]  r_s2_syn;
  // Stage 3 / outputs
  logic              r_out_vld, r_out_sbit, r_out_dbit;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_sbit_cnt, r_dbit_cnt;
  logic              r_log_vld, r_log_dbit, r_log_ovf;
  logic [ADDR_W-1:0] r_log_addr;
  logic [CHK_W-1:0]  r_log_syn;

  logic [CHK_W-1:0]  w_gen_chk;
  logic [DATA_W-1:0] w_hit;
  logic [DATA_W-1:0] w_data_cor;
  syn_class_e        w_class;
  logic              w_sbit, w_dbit, w_err;
  logic              w_log_vld_nxt, w_log_dbit_nxt, w_log_ovf_nxt;
  logic [ADDR_W-1:0] w_log_addr_nxt;
  logic [CHK_W-1:0]  w_log_syn_nxt;

  ecc_secded_syn #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
    .i_data (r_s1_data),
    .o_chk  (w_gen_chk)
  );

  // One-hot decode of the syndrome onto data bit positions.
  for (genvar j = 0; j < DATA_W; j++) begin : g_hit
    localparam logic [SYN_W-1:0] POS = SYN_W'(DPOS_F(j));
    assign w_hit[j] = (r_s2_syn == POS);
  end

  // Classify the stage-2 syndrome; s==0 with p==1 lands in SYN_PAR because
  // the overall parity bit itself is wrong.
  always_comb begin
    w_class = SYN_CLEAN;
    if (!r_s2_par) begin
      if (r_s2_syn == {SYN_W{1'b0}}) begin
        w_class = SYN_CLEAN;
      end else begin
        w_class = SYN_DBIT;
      end
    end else if (r_s2_syn > LAST_POS) begin
      w_class = SYN_DBIT;
    end else if ((r_s2_syn & (r_s2_syn - SYN_ONE)) == {SYN_W{1'b0}}) begin
      w_class = SYN_PAR;
    end else begin
      w_class = SYN_DATA;
    end
  end

  // Error flags and correction mux, qualified by the stage-2 valid.
  always_comb begin
    w_sbit     = 1'b0;
    w_dbit     = 1'b0;
    w_data_cor = r_s2_data;
    case (w_class)
      SYN_PAR:   w_sbit = r_s2_vld;
      SYN_DATA: begin
        w_sbit = r_s2_vld;
        if (!r_s2_cor_n) begin
          w_data_cor = r_s2_data ^ w_hit;
        end else begin
          w_data_cor = r_s2_data;
        end
      end
      SYN_DBIT:  w_dbit = r_s2_vld;
      default: begin
        w_sbit = 1'b0;
        w_dbit = 1'b0;
      end
    endcase
    w_err = w_sbit | w_dbit;
  end

  // Error log next state: capture when empty or acked, upgrade sbit to dbit,
  // otherwise hold and flag the overflow.
  always_comb begin
    w_log_vld_nxt  = r_log_vld;
    w_log_dbit_nxt = r_log_dbit;
    w_log_ovf_nxt  = r_log_ovf;
    w_log_addr_nxt = r_log_addr;
    w_log_syn_nxt  = r_log_syn;
    if (w_err) begin
      if (err_log_ack || !r_log_vld) begin
        w_log_vld_nxt  = 1'b1;
        w_log_dbit_nxt = w_dbit;
        w_log_ovf_nxt  = err_log_ack ? 1'b0 : r_log_ovf;
        w_log_addr_nxt = r_s2_addr;
        w_log_syn_nxt  = {r_s2_par, r_s2_syn};
      end else begin
        w_log_ovf_nxt = 1'b1;
        if (w_dbit && !r_log_dbit) begin
          w_log_dbit_nxt = 1'b1;
          w_log_addr_nxt = r_s2_addr;
          w_log_syn_nxt  = {r_s2_par, r_s2_syn};
        end else begin
          w_log_dbit_nxt = r_log_dbit;
        end
      end
    end else if (err_log_ack) begin
      w_log_vld_nxt = 1'b0;
      w_log_ovf_nxt = 1'b0;
    end else begin
      w_log_vld_nxt = r_log_vld;
    end
  end

  // Pipeline, counters and log; everything holds while ecc_clken is low.
  always_ff @(posedge ecc_clk) begin
    if (ecc_reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_cor_n <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
      r_s1_chk   <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_cor_n <= 1'b0;
      r_s2_par   <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_data  <= '0;
      r_s2_syn   <= '0;
      r_out_vld  <= 1'b0;
      r_out_sbit <= 1'b0;
      r_out_dbit <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_sbit_cnt <= '0;
      r_dbit_cnt <= '0;
      r_log_vld  <= 1'b0;
      r_log_dbit <= 1'b0;
      r_log_ovf  <= 1'b0;
      r_log_addr <= '0;
      r_log_syn  <= '0;
    end else if (ecc_clken) begin
      r_s1_vld   <= bus.in_vld;
      r_s1_cor_n <= ecc_correct_n;
      r_s1_addr  <= bus.in_addr;
      r_s1_data  <= bus.ecc_data_in;
      r_s1_chk   <= bus.ecc_chkbits_in;
      r_s2_vld   <= r_s1_vld;
      r_s2_cor_n <= r_s1_cor_n;
      r_s2_par   <= ^{r_s1_data, r_s1_chk};
      r_s2_addr  <= r_s1_addr;
      r_s2_data  <= r_s1_data;
      r_s2_syn   <= w_gen_chk[SYN_W-1:0] ^ r_s1_chk[SYN_W-1:0];
      r_out_vld  <= r_s2_vld;
      r_out_sbit <= w_sbit;
      r_out_dbit <= w_dbit;
      r_out_addr <= r_s2_addr;
      r_out_data <= w_data_cor;
      r_sbit_cnt <= sat_cnt_f(r_sbit_cnt, w_sbit, cnt_clr);
      r_dbit_cnt <= sat_cnt_f(r_dbit_cnt, w_dbit, cnt_clr);
      r_log_vld  <= w_log_vld_nxt;
      r_log_dbit <= w_log_dbit_nxt;
      r_log_ovf  <= w_log_ovf_nxt;
      r_log_addr <= w_log_addr_nxt;
      r_log_syn  <= w_log_syn_nxt;
    end
  end

  assign bus.out_vld      = r_out_vld;
  assign bus.out_addr     = r_out_addr;
  assign bus.ecc_data_out = r_out_data;
  assign bus.ecc_sbit_err = r_out_sbit;
  assign bus.ecc_dbit_err = r_out_dbit;
  assign sbit_cnt         = r_sbit_cnt;
  assign dbit_cnt         = r_dbit_cnt;
  assign err_log_vld      = r_log_vld;
  assign err_log_addr     = r_log_addr;
  assign err_log_syn      = r_log_syn;
  assign err_log_dbit     = r_log_dbit;
  assign err_log_ovf      = r_log_ovf;
  assign err_irq          = r_log_vld;

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
// tb_ecc_secded_dec_pipe
//   Directed bench for ecc_secded_dec_pipe with DATA_W=64, CHK_W=8, CNT_W=4.
//   Check bits of stimulus words come from an independent codeword-based
//   encoder; expected outputs are hand-derived constants.
module tb_ecc_secded_dec_pipe;

  localparam logic [63:0] D0    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] BIT5  = 64'h0000_0000_0000_0020;
  localparam logic [63:0] BIT40 = 64'h0000_0100_0000_0000;

  logic        ecc_clk = 1'b0;
  logic        ecc_reset, ecc_clken, ecc_correct_n, cnt_clr, err_log_ack;
  logic [3:0]  sbit_cnt, dbit_cnt;
  logic        err_log_vld, err_log_dbit, err_log_ovf, err_irq;
  logic [15:0] err_log_addr;
  logic [7:0]  err_log_syn;
  int          total = 0;
  int          bad   = 0;

  ecc_secded_dec_pipe_if #(.DATA_W(64), .CHK_W(8), .ADDR_W(16)) bus ();

  ecc_secded_dec_pipe #(.DATA_W(64), .CHK_W(8), .ADDR_W(16), .CNT_W(4)) dut (
    .ecc_clk       (ecc_clk),
    .ecc_reset     (ecc_reset),
    .ecc_clken     (ecc_clken),
    .ecc_correct_n (ecc_correct_n),
    .bus           (bus),
    .cnt_clr       (cnt_clr),
    .sbit_cnt      (sbit_cnt),
    .dbit_cnt      (dbit_cnt),
    .err_log_ack   (err_log_ack),
    .err_log_vld   (err_log_vld),
    .err_log_addr  (err_log_addr),
    .err_log_syn   (err_log_syn),
    .err_log_dbit  (err_log_dbit),
    .err_log_ovf   (err_log_ovf),
    .err_irq       (err_irq)
  );

  always #5 ecc_clk = ~ecc_clk;

  // Reference encoder: lay data into a 72-bit codeword, then XOR by position.
  function automatic logic [7:0] enc(input logic [63:0] d);
    logic [71:0] cw;
    logic [7:0]  c;
    int          k;
    cw = '0;
    k  = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k = k + 1;
      end
    end
    c = '0;
    for (int i = 0; i < 7; i++) begin
      for (int p = 1; p < 72; p++) begin
        if (p[i]) c[i] = c[i] ^ cw[p];
      end
    end
    c[7] = (^d) ^ (^c[6:0]);
    return c;
  endfunction

  task automatic tick();
    @(posedge ecc_clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [63:0] d, input logic [7:0] c,
                       input logic [15:0] a);
    bus.in_vld         = vld;
    bus.ecc_data_in    = d;
    bus.ecc_chkbits_in = c;
    bus.in_addr        = a;
  endtask

  // Present one word for a single cycle and wait until its result is visible.
  task automatic send(input logic [63:0] d, input logic [7:0] c, input logic [15:0] a);
    drive(1'b1, d, c, a);
    tick();
    bus.in_vld = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    ecc_reset = 1'b1; ecc_clken = 1'b1; ecc_correct_n = 1'b0;
    cnt_clr = 1'b0; err_log_ack = 1'b0;
    drive(1'b1, D0 ^ BIT5, enc(D0), 16'h7777);
    repeat (4) tick();
    total++;
    if ({bus.out_vld, bus.ecc_sbit_err, bus.ecc_dbit_err, bus.out_addr} !== 19'h0) begin
      bad++; $display("FAIL reset_out: got vld/s/d/addr=%h required 0",
                      {bus.out_vld, bus.ecc_sbit_err, bus.ecc_dbit_err, bus.out_addr});
    end
    total++;
    if (bus.ecc_data_out !== 64'h0) begin
      bad++; $display("FAIL reset_data: got %h required 0", bus.ecc_data_out);
    end
    total++;
    if ({sbit_cnt, dbit_cnt, err_log_vld, err_log_addr, err_log_syn, err_log_dbit,
         err_log_ovf, err_irq} !== 36'h0) begin
      bad++; $display("FAIL reset_cnt_log: got cnt=%h/%h log vld=%b irq=%b", sbit_cnt,
                      dbit_cnt, err_log_vld, err_irq);
    end
    bus.in_vld = 1'b0;
    ecc_reset  = 1'b0;
    tick();
  endtask

  task automatic test_clean();
    drive(1'b1, D0, enc(D0), 16'h0010);
    tick();
    bus.in_vld = 1'b0;
    tick();
    total++;
    if (bus.out_vld !== 1'b0) begin
      bad++; $display("FAIL clean_latency2: got out_vld=%b required 0", bus.out_vld);
    end
    tick();
    total++;
    if ({bus.out_vld, bus.out_addr, bus.ecc_data_out} !== {1'b1, 16'h0010, D0}) begin
      bad++; $display("FAIL clean_word: got vld=%b addr=%h data=%h required 1 0010 %h",
                      bus.out_vld, bus.out_addr, bus.ecc_data_out, D0);
    end
    total++;
    if ({bus.ecc_sbit_err, bus.ecc_dbit_err, sbit_cnt, dbit_cnt, err_irq} !== 11'h0) begin
      bad++; $display("FAIL clean_flags: got s=%b d=%b cnt=%h/%h irq=%b required zeros",
                      bus.ecc_sbit_err, bus.ecc_dbit_err, sbit_cnt, dbit_cnt, err_irq);
    end
    tick();
    total++;
    if (bus.out_vld !== 1'b0) begin
      bad++; $display("FAIL clean_single: got out_vld=%b required 0", bus.out_vld);
    end
  endtask

  task automatic test_sbit_correct();
    ecc_correct_n = 1'b0;
    send(D0 ^ BIT5, enc(D0), 16'h0020);
    total++;
    if ({bus.out_vld, bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err} !==
        {1'b1, D0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sbit_correct: got data=%h s=%b d=%b required %h 1 0",
                      bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, D0);
    end
    total++;
    if ({sbit_cnt, dbit_cnt} !== {4'h1, 4'h0}) begin
      bad++; $display("FAIL sbit_cnt1: got %h/%h required 1/0", sbit_cnt, dbit_cnt);
    end
    total++;
    if ({err_log_vld, err_log_addr, err_log_syn, err_log_dbit, err_log_ovf, err_irq} !==
        {1'b1, 16'h0020, 8'h8A, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL sbit_log: got vld=%b addr=%h syn=%h dbit=%b ovf=%b irq=%b required 1 0020 8a 0 0 1",
                      err_log_vld, err_log_addr, err_log_syn, err_log_dbit, err_log_ovf, err_irq);
    end
  endtask

  task automatic test_detect_only();
    ecc_correct_n = 1'b1;
    send(D0 ^ BIT5, enc(D0), 16'h0030);
    ecc_correct_n = 1'b0;
    total++;
    if ({bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err} !== {D0 ^ BIT5, 1'b1, 1'b0}) begin
      bad++; $display("FAIL detect_only: got data=%h s=%b d=%b required %h 1 0",
                      bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, D0 ^ BIT5);
    end
    total++;
    if ({sbit_cnt, err_log_addr, err_log_ovf} !== {4'h2, 16'h0020, 1'b1}) begin
      bad++; $display("FAIL detect_log: got cnt=%h addr=%h ovf=%b required 2 0020 1",
                      sbit_cnt, err_log_addr, err_log_ovf);
    end
  endtask

  task automatic test_dbit();
    send(D0 ^ BIT5 ^ BIT40, enc(D0), 16'h0040);
    total++;
    if ({bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err} !==
        {D0 ^ BIT5 ^ BIT40, 1'b0, 1'b1}) begin
      bad++; $display("FAIL dbit_word: got data=%h s=%b d=%b required %h 0 1",
                      bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, D0 ^ BIT5 ^ BIT40);
    end
    total++;
    if ({sbit_cnt, dbit_cnt} !== {4'h2, 4'h1}) begin
      bad++; $display("FAIL dbit_cnt: got %h/%h required 2/1", sbit_cnt, dbit_cnt);
    end
    // positions 10 and 47 -> syndrome 0x25, overall parity even
    total++;
    if ({err_log_vld, err_log_addr, err_log_syn, err_log_dbit, err_log_ovf} !==
        {1'b1, 16'h0040, 8'h25, 1'b1, 1'b1}) begin
      bad++; $display("FAIL dbit_log: got vld=%b addr=%h syn=%h dbit=%b ovf=%b required 1 0040 25 1 1",
                      err_log_vld, err_log_addr, err_log_syn, err_log_dbit, err_log_ovf);
    end
  endtask

  task automatic test_ack();
    err_log_ack = 1'b1;
    tick();
    err_log_ack = 1'b0;
    total++;
    if ({err_log_vld, err_log_ovf, err_irq} !== 3'b000) begin
      bad++; $display("FAIL ack_release: got vld=%b ovf=%b irq=%b required 000",
                      err_log_vld, err_log_ovf, err_irq);
    end
  endtask

  task automatic test_boundaries();
    send(D0, enc(D0) ^ 8'h80, 16'h0050);
    total++;
    if ({bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, sbit_cnt} !==
        {D0, 1'b1, 1'b0, 4'h3}) begin
      bad++; $display("FAIL overall_parity_bit: got data=%h s=%b d=%b cnt=%h required %h 1 0 3",
                      bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, sbit_cnt, D0);
    end
    total++;
    if ({err_log_vld, err_log_syn, err_log_dbit, err_log_ovf} !== {1'b1, 8'h80, 1'b0, 1'b0}) begin
      bad++; $display("FAIL overall_parity_log: got vld=%b syn=%h dbit=%b ovf=%b required 1 80 0 0",
                      err_log_vld, err_log_syn, err_log_dbit, err_log_ovf);
    end
    send(D0, enc(D0) ^ 8'h01, 16'h0051);
    total++;
    if ({bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, sbit_cnt} !==
        {D0, 1'b1, 1'b0, 4'h4}) begin
      bad++; $display("FAIL parity_pos: got data=%h s=%b d=%b cnt=%h required %h 1 0 4",
                      bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, sbit_cnt, D0);
    end
    // syndrome 127 lies beyond the last position 71
    send(D0, enc(D0) ^ 8'h7F, 16'h0052);
    total++;
    if ({bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, dbit_cnt} !==
        {D0, 1'b0, 1'b1, 4'h2}) begin
      bad++; $display("FAIL syn_out_of_range: got data=%h s=%b d=%b cnt=%h required %h 0 1 2",
                      bus.ecc_data_out, bus.ecc_sbit_err, bus.ecc_dbit_err, dbit_cnt, D0);
    end
    total++;
    if ({err_log_addr, err_log_syn, err_log_dbit} !== {16'h0052, 8'hFF, 1'b1}) begin
      bad++; $display("FAIL dbit_upgrade: got addr=%h syn=%h dbit=%b required 0052 ff 1",
                      err_log_addr, err_log_syn, err_log_dbit);
    end
    drive(1'b0, D0 ^ BIT5 ^ BIT40, enc(D0), 16'h0053);
    repeat (3) tick();
    total++;
    if ({bus.out_vld, bus.ecc_sbit_err, bus.ecc_dbit_err, sbit_cnt, dbit_cnt} !==
        {3'b000, 4'h4, 4'h2}) begin
      bad++; $display("FAIL invalid_word: got vld=%b s=%b d=%b cnt=%h/%h required 000 4/2",
                      bus.out_vld, bus.ecc_sbit_err, bus.ecc_dbit_err, sbit_cnt, dbit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int ok;
    ok = 0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++;
    if ({sbit_cnt, dbit_cnt} !== 8'h00) begin
      bad++; $display("FAIL cnt_clr_idle: got %h/%h required 0/0", sbit_cnt, dbit_cnt);
    end
    for (int cyc = 0; cyc < 22; cyc++) begin
      drive(cyc < 20, D0 ^ BIT5, enc(D0), 16'(cyc));
      tick();
      if (cyc >= 2 && bus.out_vld === 1'b1 && bus.ecc_data_out === D0 &&
          bus.ecc_sbit_err === 1'b1 && bus.out_addr === 16'(cyc - 2)) begin
        ok++;
      end
    end
    bus.in_vld = 1'b0;
    total++;
    if (ok != 20) begin
      bad++; $display("FAIL b2b_words: got %0d good words required 20", ok);
    end
    total++;
    if (sbit_cnt !== 4'hF) begin
      bad++; $display("FAIL sbit_saturate: got %h required f", sbit_cnt);
    end
  endtask

  task automatic test_cnt_clr_with_err();
    drive(1'b1, D0 ^ BIT5, enc(D0), 16'h0060);
    tick();
    bus.in_vld = 1'b0;
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++;
    if ({sbit_cnt, dbit_cnt} !== {4'h1, 4'h0}) begin
      bad++; $display("FAIL cnt_clr_err: got %h/%h required 1/0", sbit_cnt, dbit_cnt);
    end
  endtask

  task automatic test_clken();
    int          sent, got;
    logic        frz, en_edge;
    logic        snap_vld;
    logic [15:0] snap_addr;
    logic [63:0] snap_data, dk;
    sent = 0; got = 0;
    snap_vld = bus.out_vld; snap_addr = bus.out_addr; snap_data = bus.ecc_data_out;
    for (int cyc = 0; cyc < 16; cyc++) begin
      frz         = (cyc >= 4) && (cyc <= 8);
      ecc_clken   = !frz;
      cnt_clr     = frz;
      err_log_ack = frz;
      dk          = D0 ^ (64'(sent) << 32);
      drive(sent < 6, dk, enc(dk), 16'h0100 + 16'(sent));
      en_edge = ecc_clken;
      tick();
      if (en_edge) begin
        if (bus.in_vld) sent++;
        if (bus.out_vld === 1'b1) begin
          dk = D0 ^ (64'(got) << 32);
          total++;
          if ({bus.out_addr, bus.ecc_data_out} !== {16'h0100 + 16'(got), dk}) begin
            bad++; $display("FAIL clken_order: got addr=%h data=%h required %h %h",
                            bus.out_addr, bus.ecc_data_out, 16'h0100 + 16'(got), dk);
          end
          got++;
        end
        snap_vld = bus.out_vld; snap_addr = bus.out_addr; snap_data = bus.ecc_data_out;
      end else begin
        total++;
        if ({bus.out_vld, bus.out_addr, bus.ecc_data_out, sbit_cnt, err_log_vld} !==
            {snap_vld, snap_addr, snap_data, 4'h1, 1'b1}) begin
          bad++; $display("FAIL clken_frozen: got vld=%b addr=%h cnt=%h logv=%b required %b %h 1 1",
                          bus.out_vld, bus.out_addr, sbit_cnt, err_log_vld, snap_vld, snap_addr);
        end
      end
    end
    ecc_clken = 1'b1; cnt_clr = 1'b0; err_log_ack = 1'b0; bus.in_vld = 1'b0;
    total++;
    if (got != 6) begin
      bad++; $display("FAIL clken_count: got %0d words required 6", got);
    end
  endtask

  task automatic test_ack_recapture();
    drive(1'b1, D0 ^ BIT5, enc(D0), 16'h0ABC);
    tick();
    bus.in_vld = 1'b0;
    tick();
    err_log_ack = 1'b1;
    tick();
    err_log_ack = 1'b0;
    total++;
    if ({err_log_vld, err_log_ovf, err_log_addr, err_log_syn, err_log_dbit, err_irq} !==
        {1'b1, 1'b0, 16'h0ABC, 8'h8A, 1'b0, 1'b1}) begin
      bad++; $display("FAIL ack_recapture: got vld=%b ovf=%b addr=%h syn=%h dbit=%b irq=%b required 1 0 0abc 8a 0 1",
                      err_log_vld, err_log_ovf, err_log_addr, err_log_syn, err_log_dbit, err_irq);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_sbit_correct();
    test_detect_only();
    test_dbit();
    test_ack();
    test_boundaries();
    test_back_to_back();
    test_cnt_clr_with_err();
    test_clken();
    test_ack_recapture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
